// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter_pkg
//  Description : Shared types for the instruction/data memory arbiter:
//                FSM state encoding, port-ownership and memory-op enums.
//  Revision    : 1.0  initial release
// ============================================================================
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_I = 2'd1,
        ISSUE_D = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Shares one Memory port between the instruction cache
//                (read-only) and the data-side requester (loads/stores).
//                One transaction in flight; round-robin or fixed-priority
//                (data wins) arbitration. Address/store data snapshotted at
//                grant so requesters may change inputs while stalled.
//  Ports       : clk, reset (async, active-low)
//                i_read_request/i_addr -> i_read_response/i_read_data
//                d_read_request/d_write_request/d_addr/d_write_data
//                  -> d_response/d_read_data
//                memory_read/memory_write/memory_addr/memory_write_data
//                  <- memory_read_data/memory_response
//  Revision    : 1.0  initial release
// ============================================================================
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read_request,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_read_response,
    output logic [DATA_WIDTH-1:0] i_read_data,
    input  logic                  d_read_request,
    input  logic                  d_write_request,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_write_data,
    output logic                  d_response,
    output logic [DATA_WIDTH-1:0] d_read_data,
    output logic                  memory_read,
    output logic                  memory_write,
    output logic [ADDR_WIDTH-1:0] memory_addr,
    output logic [DATA_WIDTH-1:0] memory_write_data,
    input  logic [DATA_WIDTH-1:0] memory_read_data,
    input  logic                  memory_response
);

    arb_state_t            r_state;
    owner_t                r_last_grant;
    mem_op_t               r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_i_resp;
    logic                  r_d_resp;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;
    logic w_issuing;

    assign w_i_req = i_read_request;
    assign w_d_req = d_read_request | d_write_request;

    // Data wins when alone, when fixed priority is selected, or when the
    // instruction port was the last one served (round-robin tie break).
    assign w_grant_d = w_d_req &&
                       (!w_i_req || (FIXED_PRIORITY != 0) || (r_last_grant == OWNER_I));

    // Commands are decoded from registered state, so the asynchronous reset
    // drops them immediately without waiting for a clock edge.
    assign w_issuing    = (r_state == ISSUE_I) || (r_state == ISSUE_D);
    assign memory_read  = w_issuing && (r_op == OP_READ);
    assign memory_write = w_issuing && (r_op == OP_WRITE);

    assign memory_addr       = r_addr;
    assign memory_write_data = r_wdata;
    assign i_read_data       = r_rdata;
    assign d_read_data       = r_rdata;
    assign i_read_response   = r_i_resp;
    assign d_response        = r_d_resp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= OWNER_D;   // instruction port wins the first tie
            r_op         <= OP_READ;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_i_req || w_d_req) begin
                        if (w_grant_d) begin
                            r_last_grant <= OWNER_D;
                            r_addr       <= d_addr;
                            r_wdata      <= d_write_data;
                            // Read and write both high counts as a write.
                            r_op         <= d_write_request ? OP_WRITE : OP_READ;
                            r_state      <= ISSUE_D;
                        end else begin
                            r_last_grant <= OWNER_I;
                            r_addr       <= i_addr;
                            r_op         <= OP_READ;
                            r_state      <= ISSUE_I;
                        end
                    end
                end
                ISSUE_I, ISSUE_D: begin
                    if (memory_response) begin
                        r_rdata <= memory_read_data;
                        r_state <= RESPOND;
                        if (r_state == ISSUE_I) begin
                            r_i_resp <= 1'b1;
                        end else begin
                            r_d_resp <= 1'b1;
                        end
                    end
                end
                RESPOND: begin
                    r_i_resp <= 1'b0;
                    r_d_resp <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Directed self-checking bench for memory_arbiter. A
//                round-robin instance and a fixed-priority instance share
//                requester stimulus; each has its own one-cycle memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    // Round-robin instance signals
    logic        a_i_resp, a_d_resp, a_rd, a_wr, a_mresp;
    logic [31:0] a_i_data, a_d_data, a_addr, a_wdata, a_rdata;
    // Fixed-priority instance signals
    logic        b_i_resp, b_d_resp, b_rd, b_wr, b_mresp;
    logic [31:0] b_i_data, b_d_data, b_addr, b_wdata, b_rdata;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    int n_checks = 0;
    int n_errors = 0;

    memory_arbiter #(.FIXED_PRIORITY(0), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset),
        .i_read_request(i_req), .i_addr(i_addr),
        .i_read_response(a_i_resp), .i_read_data(a_i_data),
        .d_read_request(d_rd), .d_write_request(d_wr),
        .d_addr(d_addr), .d_write_data(d_wdata),
        .d_response(a_d_resp), .d_read_data(a_d_data),
        .memory_read(a_rd), .memory_write(a_wr),
        .memory_addr(a_addr), .memory_write_data(a_wdata),
        .memory_read_data(a_rdata), .memory_response(a_mresp)
    );

    memory_arbiter #(.FIXED_PRIORITY(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_fp (
        .clk(clk), .reset(reset),
        .i_read_request(i_req), .i_addr(i_addr),
        .i_read_response(b_i_resp), .i_read_data(b_i_data),
        .d_read_request(d_rd), .d_write_request(d_wr),
        .d_addr(d_addr), .d_write_data(d_wdata),
        .d_response(b_d_resp), .d_read_data(b_d_data),
        .memory_read(b_rd), .memory_write(b_wr),
        .memory_addr(b_addr), .memory_write_data(b_wdata),
        .memory_read_data(b_rdata), .memory_response(b_mresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: response one cycle after a command is seen.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_mresp <= 1'b0;
            a_rdata <= '0;
        end else begin
            a_mresp <= (a_rd || a_wr) && !a_mresp;
            if (a_rd) a_rdata <= mem_a[a_addr[7:2]];
            if (a_wr && !a_mresp) mem_a[a_addr[7:2]] <= a_wdata;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_mresp <= 1'b0;
            b_rdata <= '0;
        end else begin
            b_mresp <= (b_rd || b_wr) && !b_mresp;
            if (b_rd) b_rdata <= mem_b[b_addr[7:2]];
            if (b_wr && !b_mresp) mem_b[b_addr[7:2]] <= b_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Data transaction: checks the issued command and the returned data.
    task automatic d_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
        logic got;
        logic saw_i;
        got   = 1'b0;
        saw_i = 1'b0;
        d_wr = we; d_rd = !we; d_addr = addr; d_wdata = wdata;
        tick();
        check({tag, "_mem_write"}, {31'd0, a_wr}, {31'd0, we});
        check({tag, "_mem_read"},  {31'd0, a_rd}, {31'd0, !we});
        check({tag, "_mem_addr"},  a_addr, addr);
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (a_i_resp) saw_i = 1'b1;
            if (a_d_resp) got = 1'b1;
        end
        check({tag, "_d_response"}, {31'd0, got}, 32'd1);
        check({tag, "_no_i_response"}, {31'd0, saw_i}, 32'd0);
        if (!we) check({tag, "_d_read_data"}, a_d_data, exp_rdata);
        d_wr = 1'b0; d_rd = 1'b0;
        tick();
    endtask

    task automatic i_txn(input string tag, input logic [31:0] addr, input logic [31:0] exp_rdata);
        logic got;
        got = 1'b0;
        i_req = 1'b1; i_addr = addr;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (a_i_resp) got = 1'b1;
        end
        check({tag, "_i_response"}, {31'd0, got}, 32'd1);
        check({tag, "_i_read_data"}, a_i_data, exp_rdata);
        i_req = 1'b0;
        tick();
    endtask

    initial begin
        logic [1:0] rr_ord [0:3];
        logic [1:0] fp_ord [0:1];
        int         n_rr;
        int         n_fp;
        int         n_dresp;

        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h1000_0000 + i;
            mem_b[i] = 32'h1000_0000 + i;
        end
        mem_a[1] = 32'h00A00093; mem_b[1] = 32'h00A00093;
        mem_a[2] = 32'h11112222; mem_b[2] = 32'h11112222;
        mem_a[3] = 32'h33334444; mem_b[3] = 32'h33334444;

        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        tick(); tick();

        // Reset state
        check("rst_mem_read",  {31'd0, a_rd},     32'd0);
        check("rst_mem_write", {31'd0, a_wr},     32'd0);
        check("rst_i_resp",    {31'd0, a_i_resp}, 32'd0);
        check("rst_d_resp",    {31'd0, a_d_resp}, 32'd0);
        check("rst_mem_addr",  a_addr,            32'd0);
        check("rst_i_data",    a_i_data,          32'd0);
        reset = 1'b1;
        tick();

        // Instruction-only read with exact cycle timing
        i_req = 1'b1; i_addr = 32'h4;
        tick();
        check("ionly_mem_read_c1", {31'd0, a_rd}, 32'd1);
        check("ionly_mem_write_c1", {31'd0, a_wr}, 32'd0);
        check("ionly_mem_addr_c1", a_addr, 32'h4);
        tick();
        check("ionly_no_resp_c2", {31'd0, a_i_resp}, 32'd0);
        tick();
        check("ionly_i_resp_c3", {31'd0, a_i_resp}, 32'd1);
        check("ionly_i_data_c3", a_i_data, 32'h00A00093);
        check("ionly_mem_read_c3", {31'd0, a_rd}, 32'd0);
        check("ionly_no_d_resp_c3", {31'd0, a_d_resp}, 32'd0);
        i_req = 1'b0;
        tick();
        check("ionly_i_resp_c4", {31'd0, a_i_resp}, 32'd0);

        // Data write then read back
        d_txn("dwr", 1'b1, 32'h40, 32'hDEADBEEF, 32'h0);
        d_txn("drd", 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        // Both data requests high is treated as a write
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h44; d_wdata = 32'h5A5A5A5A;
        tick();
        check("dboth_mem_write", {31'd0, a_wr}, 32'd1);
        check("dboth_mem_read",  {31'd0, a_rd}, 32'd0);
        d_rd = 1'b0; d_wr = 1'b0;
        repeat (5) tick();
        d_txn("dboth_rd", 1'b0, 32'h44, 32'h0, 32'h5A5A5A5A);

        // Address change while the instruction read is in flight
        i_req = 1'b1; i_addr = 32'h8;
        tick();
        i_addr = 32'hE;
        tick();
        check("achg_mem_addr", a_addr, 32'h8);
        i_txn("achg", 32'hE, 32'h11112222);

        // Contention after reset, requests held continuously
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        i_req = 1'b1; i_addr = 32'h100;
        d_rd = 1'b1; d_addr = 32'h200;
        n_rr = 0; n_fp = 0;
        for (int c = 0; c < 60 && (n_rr < 4 || n_fp < 2); c++) begin
            tick();
            if (a_i_resp && n_rr < 4) begin rr_ord[n_rr] = 2'd1; n_rr++; end
            if (a_d_resp && n_rr < 4) begin rr_ord[n_rr] = 2'd2; n_rr++; end
            if (b_i_resp && n_fp < 2) begin fp_ord[n_fp] = 2'd1; n_fp++; end
            if (b_d_resp && n_fp < 2) begin fp_ord[n_fp] = 2'd2; n_fp++; end
        end
        i_req = 1'b0; d_rd = 1'b0;
        check("rr_count", n_rr, 32'd4);
        check("fp_count", n_fp, 32'd2);
        if (n_rr == 4) begin
            check("rr_grant0_I", {30'd0, rr_ord[0]}, 32'd1);
            check("rr_grant1_D", {30'd0, rr_ord[1]}, 32'd2);
            check("rr_grant2_I", {30'd0, rr_ord[2]}, 32'd1);
            check("rr_grant3_D", {30'd0, rr_ord[3]}, 32'd2);
        end
        if (n_fp == 2) begin
            check("fp_grant0_D", {30'd0, fp_ord[0]}, 32'd2);
            check("fp_grant1_D", {30'd0, fp_ord[1]}, 32'd2);
        end
        repeat (8) tick();

        // Asynchronous reset during a data write
        d_wr = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
        tick();
        check("arst_mem_write_before", {31'd0, a_wr}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_mem_write_dropped", {31'd0, a_wr}, 32'd0);
        check("arst_mem_addr_cleared", a_addr, 32'd0);
        d_wr = 1'b0;
        n_dresp = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (a_d_resp) n_dresp++;
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (a_d_resp) n_dresp++;
        end
        check("arst_no_d_response", n_dresp, 32'd0);
        i_txn("arst_after", 32'h4, 32'h00A00093);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
